register_file: RTL



---
 rtl/register_file_pkg.sv | 8 +
 rtl/register_file_decoder_onehot.sv | 11 +
 rtl/register_file.sv | 38 +++
 3 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared register-file constants and named MIPS register indices
package register_file_pkg;
    localparam int REG_ZERO   = 0;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_SP     = 29;
    localparam int REG_RA     = 31;
endpackage

// File: rtl/register_file_decoder_onehot.sv
// register_file_decoder_onehot: enable-gated one-hot decoder of a binary address
module register_file_decoder_onehot #(
    parameter int ADDR_W = 5
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] sel
);
    localparam int DEPTH = 2**ADDR_W;
    assign sel = en ? ({{(DEPTH-1){1'b0}}, 1'b1} << addr) : '0;
endmodule

// File: rtl/register_file.sv
// register_file: MIPS GPR file, one write port, two combinational read ports, r0 hardwired to zero
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b
);
    localparam int DEPTH = 2**ADDR_W;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] dec, we;
    register_file_decoder_onehot #(.ADDR_W(ADDR_W)) u_dec (
        .en   (wr_en & ~reset),
        .addr (wr_addr),
        .sel  (dec)
    );
    // we[i] is exactly the "this register is being written this cycle" condition, so it also drives bypass
    assign we = dec & ~DEPTH'(1);
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (reset) regs[i] <= '0;
            else if (we[i]) regs[i] <= wr_data;
    end
    assign rd_data_a = (BYPASS != 0 && we[rd_addr_a]) ? wr_data :
                       (rd_addr_a == ADDR_W'(REG_ZERO)) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (BYPASS != 0 && we[rd_addr_b]) ? wr_data :
                       (rd_addr_b == ADDR_W'(REG_ZERO)) ? '0 : regs[rd_addr_b];
endmodule
